// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN sequencer, trap/redirect/BTB/sequential next-PC selection.
// Optional branch target buffer enabled by defining PC_GEN_BTB_EN.
//
// state | meaning
// BOOT  | reset released, curr_addr held at RESET_VEC, pc_valid low
// RUN   | fetching, curr_addr advances every unstalled cycle
module pc_gen #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_VEC   = 32'h00000000,
    parameter int               BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_fetch_stg,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            btb_upd_valid,
    input  logic [XLEN-1:0] btb_upd_pc,
    input  logic [XLEN-1:0] btb_upd_target,
    input  logic            btb_upd_taken,
    output logic [XLEN-1:0] curr_addr,
    output logic            pc_valid,
    output logic            pred_taken,
    output logic            misalign
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          state, next_state;
    logic [XLEN-1:0] next_pc;
    logic            next_misalign;
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] seq_pc;

    assign pc_valid   = (state == RUN);
    assign seq_pc     = curr_addr + XLEN'(4);
    assign pred_taken = btb_hit;

`ifdef PC_GEN_BTB_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];
    logic [IDX_W-1:0]       rd_idx, wr_idx;
    logic [TAG_W-1:0]       rd_tag, wr_tag;
    logic                   unused_btb;

    assign rd_idx     = curr_addr[IDX_W+1:2];
    assign rd_tag     = curr_addr[XLEN-1:IDX_W+2];
    assign wr_idx     = btb_upd_pc[IDX_W+1:2];
    assign wr_tag     = btb_upd_pc[XLEN-1:IDX_W+2];
    assign unused_btb = ^btb_upd_pc[1:0];

    assign btb_hit    = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag) && pc_valid;
    assign btb_target = btb_tgt[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_valid <= '0;
        end else if (btb_upd_valid) begin
            if (btb_upd_taken)
                btb_valid[wr_idx] <= 1'b1;
            else if (btb_tag[wr_idx] == wr_tag)
                btb_valid[wr_idx] <= 1'b0;
        end
    end

    // Tag/target payload needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (rst && btb_upd_valid && btb_upd_taken) begin
            btb_tag[wr_idx] <= wr_tag;
            btb_tgt[wr_idx] <= btb_upd_target;
        end
    end
`else
    logic unused_btb;

    assign btb_hit    = 1'b0;
    assign btb_target = '0;
    assign unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken};
`endif

    always_comb begin
        next_state    = state;
        next_pc       = curr_addr;
        next_misalign = 1'b0;
        case (state)
            BOOT: begin
                next_state = RUN;
                next_pc    = RESET_VEC;
            end
            RUN: begin
                if (trap_valid) begin
                    next_pc = trap_vec;
                end else if (redirect_valid) begin
                    // A misaligned redirect target is diverted to the trap vector.
                    if (redirect_pc[1:0] != 2'b00) begin
                        next_pc       = trap_vec;
                        next_misalign = 1'b1;
                    end else begin
                        next_pc = redirect_pc;
                    end
                end else if (!stall_fetch_stg) begin
                    next_pc = btb_hit ? btb_target : seq_pc;
                end
            end
            default: begin
                next_state = BOOT;
                next_pc    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= BOOT;
            curr_addr <= RESET_VEC;
            misalign  <= 1'b0;
        end else begin
            state     <= next_state;
            curr_addr <= next_pc;
            misalign  <= next_misalign;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen; BTB expectations follow whether PC_GEN_BTB_EN is defined.
module tb_pc_gen;

`ifdef PC_GEN_BTB_EN
    localparam bit BTB_EN = 1'b1;
`else
    localparam bit BTB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_fetch_stg;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_upd_valid;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_target;
    logic        btb_upd_taken;
    logic [31:0] curr_addr;
    logic        pc_valid;
    logic        pred_taken;
    logic        misalign;

    int total  = 0;
    int passed = 0;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall_fetch_stg(stall_fetch_stg),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .btb_upd_valid  (btb_upd_valid),
        .btb_upd_pc     (btb_upd_pc),
        .btb_upd_target (btb_upd_target),
        .btb_upd_taken  (btb_upd_taken),
        .curr_addr      (curr_addr),
        .pc_valid       (pc_valid),
        .pred_taken     (pred_taken),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        stall_fetch_stg = 1'b0;
        trap_valid      = 1'b0;
        trap_vec        = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        btb_upd_valid   = 1'b0;
        btb_upd_pc      = 32'h0;
        btb_upd_target  = 32'h0;
        btb_upd_taken   = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        chk("rst_addr", curr_addr, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_pred", {31'b0, pred_taken}, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);

        // Release reset; BOOT ignores a trap request on its one cycle.
        rst = 1'b1;
        trap_valid = 1'b1;
        trap_vec   = 32'h80;
        chk("boot_valid", {31'b0, pc_valid}, 32'h0);
        chk("boot_addr", curr_addr, 32'h0);
        step();
        clear_inputs();
        chk("run0_addr", curr_addr, 32'h0);
        chk("run0_valid", {31'b0, pc_valid}, 32'h1);
        step(); chk("seq_4", curr_addr, 32'h4);
        step(); chk("seq_8", curr_addr, 32'h8);
        step(); chk("seq_c", curr_addr, 32'hC);
        step(); chk("seq_10", curr_addr, 32'h10);

        stall_fetch_stg = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h200;
        step(); chk("stall_redirect", curr_addr, 32'h200);
        redirect_valid = 1'b0;
        step(); chk("stall_hold", curr_addr, 32'h200);
        stall_fetch_stg = 1'b0;

        trap_valid     = 1'b1;
        trap_vec       = 32'h80;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        chk("prio_addr", curr_addr, 32'h80);
        chk("prio_misalign", {31'b0, misalign}, 32'h0);
        clear_inputs();

        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        trap_vec       = 32'h80;
        step();
        chk("misal_addr", curr_addr, 32'h80);
        chk("misal_pulse", {31'b0, misalign}, 32'h1);
        clear_inputs();
        step();
        chk("misal_next", curr_addr, 32'h84);
        chk("misal_clear", {31'b0, misalign}, 32'h0);

        trap_valid = 1'b1;
        trap_vec   = 32'h103;
        step();
        chk("trap_unaligned", curr_addr, 32'h103);
        chk("trap_no_misal", {31'b0, misalign}, 32'h0);
        clear_inputs();

        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step(); chk("redir_10", curr_addr, 32'h10);
        clear_inputs();

        btb_upd_valid  = 1'b1;
        btb_upd_pc     = 32'h20;
        btb_upd_target = 32'h400;
        btb_upd_taken  = 1'b1;
        step(); chk("btb_seq_14", curr_addr, 32'h14);
        clear_inputs();
        step(); chk("btb_seq_18", curr_addr, 32'h18);
        chk("btb_miss_pred", {31'b0, pred_taken}, 32'h0);
        step(); step();
        chk("btb_at_20", curr_addr, 32'h20);
        chk("btb_hit_pred", {31'b0, pred_taken}, {31'b0, BTB_EN});
        step();
        chk("btb_target", curr_addr, BTB_EN ? 32'h400 : 32'h24);

        // Not-taken update with matching tag evicts the entry.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        btb_upd_valid  = 1'b1;
        btb_upd_pc     = 32'h20;
        btb_upd_taken  = 1'b0;
        step();
        clear_inputs();
        chk("evict_addr", curr_addr, 32'h20);
        chk("evict_pred", {31'b0, pred_taken}, 32'h0);

        // A same-cycle taken write is not visible to this cycle's lookup.
        btb_upd_valid  = 1'b1;
        btb_upd_pc     = 32'h20;
        btb_upd_target = 32'h400;
        btb_upd_taken  = 1'b1;
        step();
        clear_inputs();
        chk("evict_seq_24", curr_addr, 32'h24);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        clear_inputs();
        chk("rewrite_pred", {31'b0, pred_taken}, {31'b0, BTB_EN});
        stall_fetch_stg = 1'b1;
        step();
        chk("stall_blocks_btb", curr_addr, 32'h20);
        stall_fetch_stg = 1'b0;

        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step(); chk("wrap_top", curr_addr, 32'hFFFF_FFFC);
        clear_inputs();
        step(); chk("wrap_zero", curr_addr, 32'h0);
        step(); chk("wrap_4", curr_addr, 32'h4);

        // Reset mid-operation wins over trap, redirect and BTB update.
        rst            = 1'b0;
        trap_valid     = 1'b1;
        trap_vec       = 32'h80;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        btb_upd_valid  = 1'b1;
        btb_upd_pc     = 32'h0;
        btb_upd_target = 32'h500;
        btb_upd_taken  = 1'b1;
        step();
        chk("mid_rst_addr", curr_addr, 32'h0);
        chk("mid_rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("mid_rst_misal", {31'b0, misalign}, 32'h0);
        rst = 1'b1;
        clear_inputs();
        step();
        chk("post_rst_addr", curr_addr, 32'h0);
        chk("post_rst_valid", {31'b0, pc_valid}, 32'h1);
        chk("post_rst_pred", {31'b0, pred_taken}, 32'h0);
        step();
        chk("post_rst_seq", curr_addr, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h00000000, meaning PC value loaded on reset.
REQ-003 SHALL have parameter BTB_ENTRIES, default 8, meaning BTB depth (power of two, minimum 2).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port stall_fetch_stg  input  1  holds PC when high.
REQ-007 SHALL have port trap_valid  input  1  trap redirect request.
REQ-008 SHALL have port trap_vec  input  XLEN  trap target.
REQ-009 SHALL have port redirect_valid  input  1  resolved branch/jump redirect.
REQ-010 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-011 SHALL have port btb_upd_valid  input  1  BTB update strobe.
REQ-012 SHALL have port btb_upd_pc  input  XLEN  branch PC being updated.
REQ-013 SHALL have port btb_upd_target  input  XLEN  taken target.
REQ-014 SHALL have port btb_upd_taken  input  1  branch outcome.
REQ-015 SHALL have port curr_addr  output  XLEN  current fetch PC.
REQ-016 SHALL have port pc_valid  output  1  curr_addr is a valid fetch address.
REQ-017 SHALL have port pred_taken  output  1  BTB hit on curr_addr.
REQ-018 SHALL have port misalign  output  1  one-cycle pulse: misaligned redirect target rejected.

Function
REQ-019 SHALL implement states BOOT and RUN; BOOT -> RUN on the first cycle with rst high; RUN persists until reset.
REQ-020 SHALL drive pc_valid low in BOOT and high in RUN.
REQ-021 SHALL hold curr_addr at RESET_VEC in BOOT regardless of other inputs.
REQ-022 SHALL, in RUN, select next PC by priority: trap_valid > redirect_valid > BTB hit > sequential.
REQ-023 SHALL compute sequential next PC as curr_addr + 4 modulo 2^XLEN (0xFFFFFFFC wraps to 0x00000000).
REQ-024 SHALL use the BTB target of curr_addr as next PC on a hit.
REQ-025 SHALL apply trap and redirect loads even when stall_fetch_stg is high; stall blocks only sequential and BTB advance.
REQ-026 SHALL, when redirect_valid selects and redirect_pc[1:0] != 0, load trap_vec instead and assert misalign for exactly that cycle.
REQ-027 SHALL load trap_vec unmodified (no alignment check) on trap_valid.
REQ-028 SHALL take effect one cycle after the inputs: curr_addr updates on the next rising clk edge.
REQ-029 SHALL index the BTB with curr_addr[log2(BTB_ENTRIES)+1:2]; tag is bits above the index; each entry holds valid, tag, target.
REQ-030 SHALL assert pred_taken combinationally when the indexed entry is valid, tag matches, and pc_valid is high.
REQ-031 SHALL, on btb_upd_valid with btb_upd_taken high, write valid=1, tag, target into the entry indexed by btb_upd_pc.
REQ-032 SHALL, on btb_upd_valid with btb_upd_taken low, clear valid of the indexed entry only if its tag matches.
REQ-033 SHALL make BTB writes visible to lookups from the following cycle (same-cycle lookup sees old contents).

Reset
REQ-034 SHALL, while rst is low at a clk edge, set state BOOT, curr_addr RESET_VEC, all BTB valid bits 0, misalign 0; pred_taken and pc_valid then read 0.
REQ-035 SHALL let reset override trap, redirect, stall and BTB update in the same cycle, including mid-operation.

Configuration
REQ-036 SHALL include the BTB only when macro PC_GEN_BTB_EN is defined; otherwise pred_taken is constant 0, btb_upd_* are ignored, and next PC is trap > redirect > sequential.

Verification
REQ-037 SHALL cover reset release: rst low 2 cycles then high -> curr_addr 0x0 with pc_valid 0 for one cycle, then 0x0, 0x4, 0x8 with pc_valid 1.
REQ-038 SHALL cover stall vs redirect: PC 0x10, stall high, redirect_valid=1 redirect_pc 0x200 -> next curr_addr 0x200; stall alone -> curr_addr held.
REQ-039 SHALL cover priority: trap_valid with trap_vec 0x80 and redirect to 0x300 same cycle -> curr_addr 0x80, misalign 0.
REQ-040 SHALL cover misalign: redirect_pc 0x102, trap_vec 0x80 -> curr_addr 0x80, misalign pulses one cycle.
REQ-041 SHALL cover BTB: update pc 0x20 target 0x400 taken; when curr_addr reaches 0x20 -> pred_taken 1, next 0x400; not-taken update for 0x20 -> next visit to 0x20 goes to 0x24.
REQ-042 SHALL cover wrap: redirect to 0xFFFFFFFC -> next sequential curr_addr 0x00000000.
